// File: rtl/seven_segment_scan_if.sv
// Display-side bundle of the multiplexed 7-segment driver: value/brightness
// inputs with their load request, and the registered pin outputs.
interface seven_segment_scan_if #(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 4
);
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   dp;
  logic [BRIGHT_W-1:0] bright;
  logic                load;
  logic [6:0]          seg;
  logic                seg_dp;
  logic [DIGITS-1:0]   dsen;
  logic                frame_done;

  modport master (
    output bcd, dp, bright, load,
    input  seg, seg_dp, dsen, frame_done
  );

  modport slave (
    input  bcd, dp, bright, load,
    output seg, seg_dp, dsen, frame_done
  );
endinterface

// File: rtl/seven_segment_scan.sv
// Time-multiplexed 7-segment driver with dead time, PWM brightness and a
// frame-synchronous shadow of the display data. Optional: LEADING_ZERO_BLANK_EN.
module seven_segment_scan #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int BRIGHT_W       = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int EN_ACTIVE_LOW  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  seven_segment_scan_if.slave bus
);

  localparam int SLOT_W = $clog2(CLK_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int ACT    = CLK_DIV - BLANK_CYCLES;
  localparam int STEP   = ACT >> BRIGHT_W;

  localparam logic              SEG_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic              EN_INV   = (EN_ACTIVE_LOW != 0);
  localparam logic [6:0]        SEG_OFF  = {7{SEG_INV}};
  localparam logic [DIGITS-1:0] DSEN_OFF = {DIGITS{EN_INV}};

  logic [SLOT_W-1:0]   slot_cnt;
  logic [IDX_W-1:0]    dig_idx;
  logic                pending;
  logic [4*DIGITS-1:0] shadow_bcd;
  logic [DIGITS-1:0]   shadow_dp;
  logic [BRIGHT_W-1:0] shadow_bright;

  logic [6:0]          seg_q;
  logic                seg_dp_q;
  logic [DIGITS-1:0]   dsen_q;
  logic                frame_done_q;

  logic                slot_last;
  logic                dig_last;
  logic                boundary;
  logic [31:0]         off;
  logic [31:0]         lit_len;
  logic                lit;
  logic [3:0]          cur_digit;
  logic                cur_dp;
  logic [DIGITS-1:0]   onehot;
  logic [DIGITS-1:0]   suppress;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  assign slot_last = (slot_cnt == SLOT_W'(CLK_DIV - 1));
  assign dig_last  = (dig_idx == IDX_W'(DIGITS - 1));
  assign boundary  = slot_last && dig_last;

  // NOTE: state registers use non-blocking assignments so every process
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      dig_idx  <= dig_last ? '0 : dig_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // A load only arms the capture; the inputs themselves are taken in the
  // boundary cycle so the whole next frame shows one coherent value set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= 1'b0;
      shadow_bcd    <= '0;
      shadow_dp     <= '0;
      shadow_bright <= '0;
    end else begin
      if (boundary) begin
        pending <= 1'b0;
        if (pending || bus.load) begin
          shadow_bcd    <= bus.bcd;
          shadow_dp     <= bus.dp;
          shadow_bright <= bus.bright;
        end
      end else if (bus.load) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    suppress   = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero  = upper_zero && (shadow_bcd[4*i +: 4] == 4'd0);
      suppress[i] = upper_zero && !shadow_dp[i];
    end
  end
`else
  assign suppress = '0;
`endif

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    off       = 32'(slot_cnt) - 32'(BLANK_CYCLES);
    lit_len   = 32'(shadow_bright) * 32'(STEP);
    cur_digit = shadow_bcd[4*int'(dig_idx) +: 4];
    cur_dp    = shadow_dp[dig_idx];
    onehot    = '0;
    onehot[dig_idx] = 1'b1;
    lit = (32'(slot_cnt) >= 32'(BLANK_CYCLES)) && (off < lit_len) &&
          !suppress[dig_idx];
  end

  // Pins are registered at their final polarity so reset drives the
  // inactive level directly, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= SEG_OFF;
      seg_dp_q     <= SEG_INV;
      dsen_q       <= DSEN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= boundary;
      if (lit) begin
        seg_q    <= glyph(cur_digit) ^ SEG_OFF;
        seg_dp_q <= cur_dp ^ SEG_INV;
        dsen_q   <= onehot ^ DSEN_OFF;
      end else begin
        seg_q    <= SEG_OFF;
        seg_dp_q <= SEG_INV;
        dsen_q   <= DSEN_OFF;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.seg_dp     = seg_dp_q;
  assign bus.dsen       = dsen_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: 4 digits, 64-cycle slots, 8 blank cycles,
// 2-bit brightness (step 14), active-high pins.
module tb_seven_segment_scan;

  localparam int FRAME = 256;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [1:0]  bright;
    logic [27:0] segs;     // {d3,d2,d1,d0} expected glyphs
    logic [3:0]  vis;      // digits expected to light
    int          lit_len;  // lit cycles per visible slot
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  int         lit_cnt  [4];
  int         first_on [4];
  int         last_on  [4];
  logic [6:0] seen_seg [4];
  logic       seen_dp  [4];
  int         stray;

  vec_t vecs [7];
  vec_t dark_v;
  vec_t v_old;
  vec_t v_new;

  seven_segment_scan_if #(.DIGITS(4), .BRIGHT_W(2)) bus ();

  seven_segment_scan #(
    .DIGITS(4), .CLK_DIV(64), .BLANK_CYCLES(8), .BRIGHT_W(2),
    .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 600);
    check("frame_done_seen", int'(bus.frame_done), 1);
  endtask

  // Samples one full frame starting right after a frame_done sample; sample j
  // shows counter state j. Optional input changes at samples a_at / b_at.
  task automatic measure_frame(input int a_at, input logic [15:0] a_bcd,
                               input bit a_load, input int b_at,
                               input logic [15:0] b_bcd);
    int d;
    int s;
    for (int k = 0; k < 4; k++) begin
      lit_cnt[k] = 0; first_on[k] = -1; last_on[k] = -1;
      seen_seg[k] = '0; seen_dp[k] = 1'b0;
    end
    stray = 0;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      d = j / 64;
      s = j % 64;
      if (bus.dsen != 4'd0) begin
        if (bus.dsen != (4'b0001 << d)) stray++;
        else begin
          if (lit_cnt[d] == 0) first_on[d] = s;
          last_on[d] = s;
          lit_cnt[d]++;
          seen_seg[d] = bus.seg;
          seen_dp[d]  = bus.seg_dp;
        end
      end else if (bus.seg != 7'd0 || bus.seg_dp != 1'b0) begin
        stray++;
      end
      if (bus.frame_done != (j == FRAME - 1)) stray++;
      bus.load = 1'b0;
      if (j == a_at) begin
        bus.bcd  = a_bcd;
        bus.load = a_load;
      end
      if (j == b_at) bus.bcd = b_bcd;
    end
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    int exp_lit;
    for (int d = 0; d < 4; d++) begin
      exp_lit = v.vis[d] ? v.lit_len : 0;
      check($sformatf("%s_d%0d_lit", tag, d), lit_cnt[d], exp_lit);
      if (exp_lit > 0) begin
        check($sformatf("%s_d%0d_first", tag, d), first_on[d], 8);
        check($sformatf("%s_d%0d_last", tag, d), last_on[d], 8 + exp_lit - 1);
        check($sformatf("%s_d%0d_seg", tag, d), int'(seen_seg[d]),
              int'(v.segs[d*7 +: 7]));
        check($sformatf("%s_d%0d_dp", tag, d), int'(seen_dp[d]), int'(v.dp[d]));
      end
    end
    check({tag, "_stray"}, stray, 0);
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    bus.bcd    = v.bcd;
    bus.dp     = v.dp;
    bus.bright = v.bright;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
    wait_fd();
  endtask

  task automatic count_to_fd(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 600);
    check(name, n, FRAME);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0] = '{16'hF328, 4'b0001, 2'd3, {7'h71, 7'h4F, 7'h5B, 7'h7F}, 4'b1111, 42};
    vecs[1] = '{16'hF328, 4'b0001, 2'd1, {7'h71, 7'h4F, 7'h5B, 7'h7F}, 4'b1111, 14};
    vecs[2] = '{16'hF328, 4'b0001, 2'd0, {7'h71, 7'h4F, 7'h5B, 7'h7F}, 4'b0000, 0};
    vecs[3] = '{16'h1234, 4'b1010, 2'd2, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111, 28};
    vecs[4] = '{16'hABCD, 4'b0000, 2'd3, {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b1111, 42};
    vecs[5] = '{16'h9076, 4'b1111, 2'd3, {7'h6F, 7'h3F, 7'h07, 7'h7D}, 4'b1111, 42};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[6] = '{16'h0050, 4'b0000, 2'd3, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'b0011, 42};
`else
    vecs[6] = '{16'h0050, 4'b0000, 2'd3, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'b1111, 42};
`endif
    dark_v = '{16'h0000, 4'b0000, 2'd0, 28'd0, 4'b0000, 0};

    // Reset state and free-running dark scan.
    rst_n      = 1'b0;
    bus.bcd    = '0;
    bus.dp     = '0;
    bus.bright = '0;
    bus.load   = 1'b0;
    #23;
    check("rst_seg", int'(bus.seg), 0);
    check("rst_seg_dp", int'(bus.seg_dp), 0);
    check("rst_dsen", int'(bus.dsen), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_to_fd("first_frame_len");
    for (int f = 0; f < 3; f++) begin
      measure_frame(-1, 16'h0, 1'b0, -1, 16'h0);
      check_frame($sformatf("dark%0d", f), dark_v);
    end

    // Table of loaded values.
    for (int i = 0; i < 7; i++) begin
      apply_vec(vecs[i]);
      measure_frame(-1, 16'h0, 1'b0, -1, 16'h0);
      check_frame($sformatf("vec%0d", i), vecs[i]);
    end

    // Load mid-frame: old values hold until the boundary.
    apply_vec(vecs[0]);
    measure_frame(100, 16'h1234, 1'b1, -1, 16'h0);
    check_frame("midload_old", vecs[0]);
    v_new = '{16'h1234, 4'b0001, 2'd3, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111, 42};
    measure_frame(-1, 16'h0, 1'b0, -1, 16'h0);
    check_frame("midload_new", v_new);

    // Inputs are taken at the boundary, not when load was seen.
    measure_frame(100, 16'h5678, 1'b1, 200, 16'h9999);
    check_frame("sample_old", v_new);
    v_old = '{16'h9999, 4'b0001, 2'd3, {7'h6F, 7'h6F, 7'h6F, 7'h6F}, 4'b1111, 42};
    measure_frame(-1, 16'h0, 1'b0, -1, 16'h0);
    check_frame("sample_new", v_old);

    // Change without load is never shown.
    measure_frame(50, 16'h1111, 1'b0, -1, 16'h0);
    check_frame("noload_a", v_old);
    measure_frame(-1, 16'h0, 1'b0, -1, 16'h0);
    check_frame("noload_b", v_old);

    // Load in the boundary cycle itself; pending must not linger.
    measure_frame(254, 16'hABCD, 1'b1, -1, 16'h0);
    check_frame("bload_old", v_old);
    v_new = '{16'hABCD, 4'b0001, 2'd3, {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b1111, 42};
    measure_frame(30, 16'h1111, 1'b0, -1, 16'h0);
    check_frame("bload_new", v_new);
    measure_frame(-1, 16'h0, 1'b0, -1, 16'h0);
    check_frame("bload_hold", v_new);

    // Asynchronous reset while digit 2 is lit.
    wait_fd();
    repeat (149) @(negedge clk);
    check("pre_rst_dsen", int'(bus.dsen), 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dsen", int'(bus.dsen), 0);
    check("async_rst_seg", int'(bus.seg), 0);
    check("async_rst_seg_dp", int'(bus.seg_dp), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_to_fd("post_rst_frame_len");
    measure_frame(-1, 16'h0, 1'b0, -1, 16'h0);
    check_frame("post_rst_dark", dark_v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
Name: seven_segment_scan

Overview:
Parametrised, time-multiplexed 7-segment display driver. It is the successor to the fixed 4-digit seven_segment and adds:
- configurable digit count and scan rate
- anti-ghosting dead time between digits
- per-digit decimal point
- PWM brightness
- double-buffered, frame-synchronous data update

It sits between the readout logic (BCD/hex values) and the board display pins.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
CLK_DIV, 1000, clk cycles per digit slot (>= BLANK_CYCLES + 2**BRIGHT_W)
BLANK_CYCLES, 16, dead-time cycles at start of each slot, all digits off
BRIGHT_W, 4, brightness code width
SEG_ACTIVE_LOW, 0, 1 = seg/seg_dp driven active-low
EN_ACTIVE_LOW, 0, 1 = dsen driven active-low

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
bcd  in  4*DIGITS  digit values, digit i = bcd[4i+3:4i], digit 0 = least significant
dp  in  DIGITS  decimal point per digit
bright  in  BRIGHT_W  brightness code, 0 = dark
load  in  1  request capture of bcd/dp/bright at next frame boundary
seg  out  7  segments {g,f,e,d,c,b,a}, bit0 = a
seg_dp  out  1  decimal point segment
dsen  out  DIGITS  digit enables, one-hot or zero
frame_done  out  1  one-cycle pulse at the frame boundary

Behaviour:
- Reset (async assert, sync release): all counters 0; pending cleared; shadow bcd/dp = 0; shadow bright = 0.
- Reset output levels: frame_done=0; seg/seg_dp/dsen at their inactive level (0 when the polarity param is 0, all-ones when 1).
- Counters:
  - slot_cnt runs 0..CLK_DIV-1.
  - On wrap, dig_idx advances 0..DIGITS-1, then back to 0.
  - Frame = DIGITS*CLK_DIV cycles.
- Lit window: ACT = CLK_DIV-BLANK_CYCLES; STEP = ACT >> BRIGHT_W; off = slot_cnt-BLANK_CYCLES.
  - Digit dig_idx is lit iff slot_cnt >= BLANK_CYCLES and off < shadow_bright*STEP.
  - Lit cycles per slot = bright*STEP.
  - bright=0 never lights.
- Output timing: all outputs registered, 1-cycle latency from counter state (d,s) to pins.
  - When not lit: dsen inactive and seg/seg_dp inactive.
  - When lit: dsen bit dig_idx active, others inactive.
- Glyphs (active-high hex):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - seg_dp = shadow dp[dig_idx].
- Load handshake: a load pulse in any cycle sets pending.
  - Frame boundary = cycle with dig_idx=DIGITS-1, slot_cnt=CLK_DIV-1.
  - At the boundary, if pending or load is high, shadow <= inputs and pending clears.
  - Inputs are sampled in the boundary cycle itself, not at the load cycle.
- frame_done: asserted in the cycle after the boundary cycle, every frame, regardless of load.
- Load and boundary in the same cycle: capture occurs; pending ends cleared.
- Mid-frame input changes without load are never seen.
- Reset mid-frame: pins go to inactive asynchronously, no clock edge needed. Scan restarts at digit 0, slot 0.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digit i (i>0) is suppressed (dsen, seg and seg_dp inactive for the whole slot) when all of the following hold:
  - shadow digit i = 0
  - every shadow digit above i = 0
  - shadow dp[i] = 0
- Digit 0 is never blanked.
- Undefined: every digit is displayed, zeros shown as 3F.
- Scan timing is identical in both builds.

Test Plan:
Common setup: DIGITS=4, CLK_DIV=64, BLANK_CYCLES=8, BRIGHT_W=2, active-high (ACT=56, STEP=14).
1. Reset, no load: rst_n low → seg=0, dsen=0, frame_done=0. After release, dsen stays 0 for 3 frames; frame_done pulses every 256 cycles.
2. bcd=16'hF328, dp=4'b0001, bright=3, one load pulse → after next frame_done, each slot: dsen off 8 cycles then one-hot for 42 cycles.
   - digit0 seg=7F, seg_dp=1
   - digit1 seg=5B; digit2 seg=4F; digit3 seg=71
3. bright=1 then load → 14 lit cycles per slot; bright=0 then load → dsen=0 all frame.
4. Load at cycle 100 of the frame with new bcd=16'h1234 → pins keep old values until the boundary; the following frame shows 06/5B/4F/66 on digits 3..0.
5. rst_n low at cycle 20 of digit 2 slot while lit → dsen=0, seg=0 before the next clk edge; after release, scan resumes at digit 0, slot 0, dark.
6. bcd=16'h0050, dp=0, bright=3, loaded: with LEADING_ZERO_BLANK_EN digits 3 and 2 stay dark, digit1=6D, digit0=3F; without the macro digit3=3F, digit2=3F.
